// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, NOP encoding,
// fetch FSM state encoding and the instruction-alignment mask.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [1:0]  ALIGN_MASK       = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of {PC, instruction} pairs with flush; DEPTH must be
// a power of two so the pointers wrap naturally.
module instruction_fetch_unit_fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0] push_instr,
  output logic [CW-1:0]         count,
  output logic [DATA_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0] head_instr
);

  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_d    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_d [DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // A push into a full queue is legal only alongside a pop; the slot
      // being overwritten is the head, which has already been read this cycle.
      if (push) begin
        pc_mem_d[wr_ptr_q]    = push_pc;
        instr_mem_d[wr_ptr_q] = push_instr;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_pc    = pc_mem_q[rd_ptr_q];
  assign head_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the fetch PC, buffers ROM words in a small queue for decode
// and handles redirects, halting with a sticky fault on a misaligned target.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_Target_i,
  input  logic                  Ready_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PC_Plus_4_o,
  output logic                  Fault_o,
  output logic [DATA_WIDTH-1:0] Fault_Address_o
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;

  logic [CW-1:0]         q_count;
  logic [DATA_WIDTH-1:0] q_head_pc, q_head_instr;
  logic                  q_empty, head_valid, do_pop, do_push, do_flush;
  logic [DATA_WIDTH-1:0] pc_out;

  instruction_fetch_unit_fetch_queue #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .flush     (do_flush),
    .push_pc   (fetch_pc_q),
    .push_instr(Instruction_i),
    .count     (q_count),
    .head_pc   (q_head_pc),
    .head_instr(q_head_instr)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;

    q_empty    = (q_count == '0);
    head_valid = !q_empty && !Redirect_i && (state_q == ST_RUN);
    do_pop     = head_valid && Ready_i;
    do_push    = (state_q == ST_RUN) && !Redirect_i &&
                 ((q_count < CW'(QUEUE_DEPTH)) || do_pop);
    do_flush   = (state_q == ST_RUN) && Redirect_i;

    if (do_push) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);

    // Redirect wins over push/pop; a misaligned target freezes fetch for good.
    if (do_flush) begin
      if ((Redirect_Target_i[1:0] & ALIGN_MASK) != 2'b00) begin
        state_d      = ST_HALT;
        fault_d      = 1'b1;
        fault_addr_d = Redirect_Target_i;
      end else begin
        fetch_pc_d = Redirect_Target_i;
      end
    end

    pc_out    = q_empty ? last_pc_q : q_head_pc;
    last_pc_d = pc_out;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_PC;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      last_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      last_pc_q    <= last_pc_d;
    end
  end

  assign Address_o       = fetch_pc_q;
  assign Valid_o         = head_valid;
  assign Instruction_o   = q_empty ? NOP_INSTR : q_head_instr;
  assign PC_o            = pc_out;
  assign PC_Plus_4_o     = pc_out + DATA_WIDTH'(4);
  assign Fault_o         = fault_q;
  assign Fault_Address_o = fault_addr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed test-plan scenarios followed by random traffic,
// all compared against a queue-based reference model of the fetch unit.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset, redirect, ready;
  logic [31:0] target, rom_word;
  logic [31:0] addr, instr, pc, pc_plus_4, fault_addr;
  logic        valid, fault;

  int compare_count  = 0;
  int mismatch_count = 0;

  entry_t      m_q[$];
  logic [31:0] m_fetch, m_faddr, m_last;
  logic        m_halted, m_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_read(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  assign rom_word = rom_read(addr);

  instruction_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .Redirect_i       (redirect),
    .Redirect_Target_i(target),
    .Ready_i          (ready),
    .Instruction_i    (rom_word),
    .Address_o        (addr),
    .Valid_o          (valid),
    .Instruction_o    (instr),
    .PC_o             (pc),
    .PC_Plus_4_o      (pc_plus_4),
    .Fault_o          (fault),
    .Fault_Address_o  (fault_addr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    logic [31:0] exp_pc;
    exp_pc = (m_q.size() != 0) ? m_q[0].pc : m_last;
    checkOutput("address",    addr, m_fetch);
    checkOutput("valid",      {31'd0, valid},
                {31'd0, (m_q.size() != 0) && !redirect && !m_halted});
    checkOutput("instr",      instr, (m_q.size() != 0) ? m_q[0].instr : NOP_INSTR);
    checkOutput("pc",         pc, exp_pc);
    checkOutput("pc_plus_4",  pc_plus_4, exp_pc + 32'd4);
    checkOutput("fault",      {31'd0, fault}, {31'd0, m_fault});
    checkOutput("fault_addr", fault_addr, m_faddr);
  endtask

  // Reference behaviour for one rising edge, using the inputs now on the pins.
  task automatic modelStep();
    entry_t e;
    if (!reset) begin
      m_q.delete();
      m_fetch  = RST_PC;
      m_last   = RST_PC;
      m_halted = 1'b0;
      m_fault  = 1'b0;
      m_faddr  = 32'd0;
    end else begin
      m_last = (m_q.size() != 0) ? m_q[0].pc : m_last;
      if (!m_halted) begin
        if (redirect) begin
          m_q.delete();
          if (target[1:0] != 2'b00) begin
            m_halted = 1'b1;
            m_fault  = 1'b1;
            m_faddr  = target;
          end else begin
            m_fetch = target;
          end
        end else begin
          if (m_q.size() != 0 && ready) void'(m_q.pop_front());
          if (m_q.size() < DEPTH) begin
            e.pc    = m_fetch;
            e.instr = rom_read(m_fetch);
            m_q.push_back(e);
            m_fetch = m_fetch + 32'd4;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] t,
                               input logic rdy);
    reset    = r;
    redirect = rd;
    target   = t;
    ready    = rdy;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        r, rd, rdy;
    logic [31:0] t;
    reset    = 1'b0;
    redirect = 1'b0;
    target   = 32'd0;
    ready    = 1'b1;
    repeat (2) @(posedge clk);
    modelStep();
    #1;

    // Streaming after reset release
    repeat (4) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Back-pressure then drain
    repeat (5) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Aligned redirect while full
    repeat (3) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0040_0100, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Misaligned redirect, later redirect ignored
    applyStimulus(1'b1, 1'b1, 32'h0040_0102, 1'b1);
    checkOutput("halt_fault",      {31'd0, fault}, 32'd1);
    checkOutput("halt_fault_addr", fault_addr, 32'h0040_0102);
    repeat (2) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0040_0200, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("halt_sticky_addr", fault_addr, 32'h0040_0102);

    // Reset then PC wrap-around
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (6) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Mid-stream reset with one entry queued, without and with redirect
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_instr", instr, 32'h0000_0013);
    checkOutput("rst_addr",  addr, 32'h0040_0000);
    checkOutput("rst_fault", {31'd0, fault}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0040_0300, 1'b1);
    checkOutput("rst_redir_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_redir_instr", instr, 32'h0000_0013);
    checkOutput("rst_redir_addr",  addr, 32'h0040_0000);
    checkOutput("rst_redir_fault", {31'd0, fault}, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      rd = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0:       t = $urandom();
        1:       t = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
        default: t = RST_PC + ($urandom_range(0, 255) << 2);
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r, rd, t, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the program memory ROM.
- Owns the fetch PC, drives the ROM address, and captures the returned instruction word together with its PC.
- Buffers up to QUEUE_DEPTH fetched instructions in a small queue, then hands them to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump) by flushing the queue. Halts with a fault on a misaligned redirect target.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction words.
- RESET_PC, 32'h0040_0000, fetch PC loaded on reset.
- QUEUE_DEPTH, 2, number of fetched {PC, instruction} entries buffered (power of two, ≥2).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- Redirect_i  input  1  control-flow change this cycle.
- Redirect_Target_i  input  DATA_WIDTH  new fetch PC when Redirect_i=1.
- Ready_i  input  1  decode accepts the head entry this cycle.
- Instruction_i  input  DATA_WIDTH  word returned combinationally by program memory for Address_o.
- Address_o  output  DATA_WIDTH  byte address to program memory (memory indexes bits [16:2]).
- Valid_o  output  1  head entry valid for decode.
- Instruction_o  output  DATA_WIDTH  head instruction.
- PC_o  output  DATA_WIDTH  PC of head instruction.
- PC_Plus_4_o  output  DATA_WIDTH  PC_o + 4, modulo 2^32.
- Fault_o  output  1  sticky misaligned-target fault.
- Fault_Address_o  output  DATA_WIDTH  offending target.

Behaviour:
- Reset (reset=0 at a rising edge) applies regardless of other inputs, including mid-operation:
  - fetch_pc=RESET_PC, queue count=0, state=RUN.
  - Valid_o=0, Instruction_o=32'h0000_0013 (NOP), PC_o=RESET_PC, PC_Plus_4_o=RESET_PC+4.
  - Fault_o=0, Fault_Address_o=0.
- Address_o = fetch_pc, purely from the register (no combinational path from inputs).
- Head outputs:
  - Valid_o = (count!=0) && !Redirect_i && state==RUN.
  - When the queue is empty, Instruction_o=NOP and PC_o holds its last value.
- Pop: Valid_o && Ready_i.
- Push, in RUN with no redirect:
  - Condition: count<QUEUE_DEPTH, or count==QUEUE_DEPTH with a pop in the same cycle.
  - Action: write {fetch_pc, Instruction_i} at the tail; fetch_pc <= fetch_pc+4 (wraps 32'hFFFF_FFFC -> 0).
- Full with no pop: no push, fetch_pc holds, Address_o stable.
- Simultaneous push and pop: count unchanged, order preserved.
- Fetch throughput: 1 instruction/cycle sustained with Ready_i=1.
- Latency: fetch to Valid_o is 1 cycle.
- Redirect in RUN has priority over push and pop:
  - The queue is flushed (count<=0); no transfer completes that cycle.
  - If Redirect_Target_i[1:0]==0: fetch_pc<=target. Valid_o=0 in the next cycle; the target instruction is presented with Valid_o=1 two cycles after the redirect cycle.
  - If Redirect_Target_i[1:0]!=0: go to HALT; Fault_o<=1, Fault_Address_o<=target; fetch_pc unchanged.
- States:
  - RUN: normal fetch.
  - HALT: no push, no pop, Valid_o=0, redirects ignored. Exit only via reset.
- Back-to-back redirects: the last one wins; each flushes the queue.

Decomposition:
- Shared definitions file / package holds:
  - RESET_PC default.
  - NOP encoding 32'h0000_0013.
  - State encoding (RUN=1'b0, HALT=1'b1).
  - Instruction-alignment mask 2'b11.
- Sub-module fetch_queue: parameterised synchronous FIFO of {PC, instruction} with push, pop, flush, count, head outputs, and a synchronous active-low reset.
- The top level holds fetch_pc, the FSM and the push/pop/redirect arbitration.

Test Plan:
- Reset release, Ready_i=1, ROM returns PC-derived words:
  - Address_o = 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
  - Valid_o rises 1 cycle after reset release with PC_o=0x00400000; one instruction per cycle thereafter.
- Ready_i=0 for 5 cycles after the first fetch:
  - count saturates at 2; Address_o freezes at 0x00400008.
  - Head stays PC_o=0x00400000.
  - On Ready_i=1, PCs 0x00400000, 0x00400004, 0x00400008 pop in order with no loss or duplicate.
- Redirect_i=1, Redirect_Target_i=0x00400100 while queue full:
  - Valid_o=0 during the redirect cycle and the next cycle.
  - Next Address_o=0x00400100; Valid_o=1 with PC_o=0x00400100 two cycles after the redirect.
- Redirect_Target_i=0x00400102:
  - Fault_o=1 and Fault_Address_o=0x00400102 next cycle; Valid_o stays 0.
  - A later redirect to 0x00400200 is ignored; only reset clears the fault.
- Redirect to 0xFFFFFFF8, Ready_i=1: fetches 0xFFFFFFF8, 0xFFFFFFFC, then 0x00000000; PC_Plus_4_o for 0xFFFFFFFC is 0x00000000.
- Assert reset=0 mid-stream with the queue holding 1 entry:
  - After the edge: Valid_o=0, Instruction_o=0x00000013, Address_o=0x00400000, Fault_o=0.
  - Behaviour is identical with Redirect_i=1 in the same cycle.
